// File: rtl/modmul_interleaved.sv
// Runtime-modulus interleaved (Blakley, radix-2) modular multiplier: Q = (X*Y) mod M, one multiplier bit per clock.
// Optional build macro MODMUL_PRECHECK_EN adds an operand range check that short-circuits bad operands to err=1.
module modmul_interleaved #(
    parameter int WIDTH = 256
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] M,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] x_r, x_s;
    logic [WIDTH-1:0] y_r, y_s;
    logic [WIDTH-1:0] m_r, m_s;
    logic [WIDTH:0]   r_r, r_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic             out_valid_r, out_valid_s;
    logic             err_r, err_s;
    logic             in_ready_r, in_ready_s;
    logic             busy_r, busy_s;

    logic [WIDTH:0]   m_ext_s;
    logic [WIDTH:0]   dbl_s;
    logic [WIDTH:0]   t_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   u_s;
    logic             range_bad_s;

    // One Blakley step: T = 2R mod M, then U = (T + Y) mod M when the current X bit is set.
    always_comb begin
        m_ext_s = {1'b0, m_r};
        dbl_s   = r_r << 1'b1;
        if (dbl_s >= m_ext_s) begin
            t_s = dbl_s - m_ext_s;
        end else begin
            t_s = dbl_s;
        end
        sum_s = t_s + {1'b0, y_r};
        if (x_r[cnt_r]) begin
            if (sum_s >= m_ext_s) begin
                u_s = sum_s - m_ext_s;
            end else begin
                u_s = sum_s;
            end
        end else begin
            u_s = t_s;
        end
    end

`ifdef MODMUL_PRECHECK_EN
    // Operand range check evaluated on the live inputs at acceptance.
    always_comb begin
        range_bad_s = (X >= M) || (Y >= M) || (M < WIDTH'(2));
    end
`else
    assign range_bad_s = 1'b0;
`endif

    // Next-state and next-register values for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        y_s         = y_r;
        m_s         = m_r;
        r_s         = r_r;
        cnt_s       = cnt_r;
        q_s         = q_r;
        out_valid_s = out_valid_r;
        err_s       = err_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    x_s   = X;
                    y_s   = Y;
                    m_s   = M;
                    r_s   = '0;
                    cnt_s = CNT_W'(WIDTH - 1);
                    if (range_bad_s) begin
                        q_s         = '0;
                        out_valid_s = 1'b1;
                        err_s       = 1'b1;
                        state_s     = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                r_s = u_s;
                if (cnt_r == '0) begin
                    q_s         = u_s[WIDTH-1:0];
                    out_valid_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                // Q is left untouched on handoff so it keeps the last result.
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    err_s       = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                err_s       = 1'b0;
                state_s     = IDLE;
            end
        endcase
        in_ready_s = (state_s == IDLE);
        busy_s     = (state_s != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r     <= IDLE;
            x_r         <= '0;
            y_r         <= '0;
            m_r         <= '0;
            r_r         <= '0;
            cnt_r       <= '0;
            q_r         <= '0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            m_r         <= m_s;
            r_r         <= r_s;
            cnt_r       <= cnt_s;
            q_r         <= q_s;
            out_valid_r <= out_valid_s;
            err_r       <= err_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign Q         = q_r;
    assign err       = err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_modmul_interleaved.sv
// Self-checking bench for modmul_interleaved: arithmetic reference model, per-cycle handshake/result compare, directed pins.
module tb_modmul_interleaved;

    localparam int W = 16;
`ifdef MODMUL_PRECHECK_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic [W-1:0] M = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] Q;
    logic         err;
    logic         busy;

    modmul_interleaved #(.WIDTH(W)) dut (
        .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .M(M), .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .err(err), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        longint unsigned q;
        bit              e;
        bit              chk;
        int              due;
    } exp_t;

    exp_t            exp_q[$];
    int              acc_edges[$];
    int              vectors = 0;
    int              miscompares = 0;
    int              cyc = 0;
    bit              mon_en = 1'b0;
    longint unsigned last_q = 0;
    bit              last_err = 1'b0;
    int              last_acc = 0;
    int              last_val = 0;
    bit              exp_busy;
    bit              oor;
    exp_t            ent;

    function automatic longint unsigned model(longint unsigned x, longint unsigned y, longint unsigned m);
        if (m == 0) return 0;
        return (x * y) % m;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Compare process: every cycle, DUT handshake and result against the queue of outstanding operations.
    always @(negedge clock) begin
        if (mon_en) begin
            exp_busy = (exp_q.size() != 0);
            check("busy", busy, exp_busy);
            check("in_ready", in_ready, !exp_busy);
            if (exp_q.size() != 0) begin
                check("out_valid", out_valid, cyc >= exp_q[0].due);
                if (out_valid) begin
                    if (cyc == exp_q[0].due) last_val = cyc;
                    if (exp_q[0].chk) check("Q", Q, exp_q[0].q);
                    check("err", err, exp_q[0].e);
                    if (out_ready && !rst) begin
                        last_q   = Q;
                        last_err = err;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("out_valid_idle", out_valid, 0);
            end
            if (rst) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                oor     = (X >= M) || (Y >= M) || (M < 2);
                ent.e   = PRE && oor;
                ent.q   = ent.e ? 0 : model(X, Y, M);
                ent.chk = !oor || PRE;
                ent.due = cyc + 1 + (ent.e ? 0 : W);
                exp_q.push_back(ent);
                last_acc = cyc + 1;
                acc_edges.push_back(cyc + 1);
            end
        end
    end

    task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] m, bit hold);
        int n = 0;
        X = x; Y = y; M = m; in_valid = 1'b1;
        while (!in_ready && n < W * 4) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 1, 0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        if (!hold) in_valid = 1'b0;
        X = W'($urandom); Y = W'($urandom); M = W'($urandom);
    endtask

    task automatic wait_done(bit rnd_ready);
        int n = 0;
        while (busy && n < W * 8 + 40) begin
            if (rnd_ready) out_ready = ($urandom_range(2, 0) != 0);
            @(posedge clock); #1;
            n++;
        end
        out_ready = 1'b1;
        if (busy) begin
            check("done_timeout", 1, 0);
            repeat (4) @(posedge clock);
            #1;
        end
    endtask

    task automatic rnd_op(output logic [W-1:0] x, output logic [W-1:0] y, output logic [W-1:0] m);
        m = W'($urandom_range(65535, 2));
        x = W'($urandom % m);
        y = W'($urandom % m);
        if ($urandom_range(7, 0) == 0) x = m - W'(1);
        if ($urandom_range(7, 0) == 0) y = W'(0);
    endtask

    initial begin
        logic [W-1:0] rx, ry, rm;
        int base;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_Q", Q, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        mon_en = 1'b1;

        send(7, 9, 13, 0);
        wait_done(0);
        check("q_7_9_13", last_q, 11);
        check("err_7_9_13", last_err, 0);
        check("lat_7_9_13", last_val - last_acc, W);

        out_ready = 1'b0;
        send(200, 250, 251, 0);
        for (int n = 0; n < W * 4 && !out_valid; n++) begin
            @(posedge clock); #1;
        end
        repeat (5) @(posedge clock);
        #1;
        check("bp_in_ready", in_ready, 0);
        check("bp_Q", Q, 51);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_handoff_valid", out_valid, 0);
        check("bp_in_ready_after", in_ready, 1);
        check("bp_last_q", last_q, 51);

        send(16'd65520, 16'd65520, 16'd65521, 0);
        wait_done(0);
        check("q_mminus1_sq", last_q, 1);
        send(16'd0, 16'd65520, 16'd65521, 0);
        wait_done(0);
        check("q_x_zero", last_q, 0);
        check("lat_x_zero", last_val - last_acc, W);

        send(5, 3, 11, 0);
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b1;
        @(posedge clock); #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        rst = 1'b0;
        repeat (W + 4) @(posedge clock);
        #1;
        send(4, 6, 7, 0);
        wait_done(0);
        check("q_after_abort", last_q, 3);

        if (PRE) begin
            send(13, 2, 13, 0);
            wait_done(0);
            check("pre_err_x_eq_m", last_err, 1);
            check("pre_q_x_eq_m", last_q, 0);
            check("pre_lat", last_val - last_acc, 0);
            send(0, 0, 1, 0);
            wait_done(0);
            check("pre_err_m1", last_err, 1);
        end
        send(12, 12, 13, 0);
        wait_done(0);
        check("q_12_12_13", last_q, 1);
        check("err_12_12_13", last_err, 0);
        check("lat_12_12_13", last_val - last_acc, W);

        base = acc_edges.size();
        for (int i = 0; i < 4; i++) begin
            rnd_op(rx, ry, rm);
            send(rx, ry, rm, i < 3);
        end
        wait_done(0);
        for (int i = 1; i < 4; i++) begin
            if (base + i < acc_edges.size())
                check("b2b_spacing", acc_edges[base + i] - acc_edges[base + i - 1], W + 2);
            else
                check("b2b_missing", 0, 1);
        end

        for (int i = 0; i < 40; i++) begin
            rnd_op(rx, ry, rm);
            if (i == 0) begin rx = 1; ry = 1; rm = 2; end
            send(rx, ry, rm, 0);
            wait_done(1);
        end
        repeat (3) @(posedge clock);
        #1;
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
